stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Run-control sequencer for the stopwatch datapath. Accepts start/stop/reset requests, runs an IDLE/RUNNING/PAUSED state machine, and divides the system clock into one-second ticks. It owns the 0–59 seconds count and drives the combinational increment and clear requests into the 0–99 minutes counter, so both counters advance or clear on the same clock edge.

## Interface
- `TICKS_PER_SEC`, default 1: number of `clk` cycles per second. Must be ≥ 1. A value of 1 means every running cycle is one second.
- `clk` in 1: the single system clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level request to run, sampled each edge.
- `stop` in 1: level request to pause, sampled each edge.
- `reset` in 1: synchronous clear request, sampled each edge.
- `minutes_inc` out 1: combinational increment request to the minutes counter.
- `minutes_clr` out 1: combinational clear request to the minutes counter.
- `seconds` out 6: current seconds, 0–59.
- `state` out 2: 00 IDLE, 01 RUNNING, 10 PAUSED. Code 11 is never produced.
- `running` out 1: high while `state` is RUNNING.

## Operation
- **Input priority each edge:** `reset` > `stop` > `start`.
- **Transitions:**
  - Any state with `reset` → IDLE. `seconds` and the prescaler are cleared.
  - IDLE with `start` (and no `stop`) → RUNNING. IDLE with `stop` → IDLE.
  - RUNNING with `stop` → PAUSED.
  - PAUSED with `start` (and no `stop`) → RUNNING.
  - `start` while already RUNNING is a no-op. `stop` in IDLE or PAUSED is a no-op.
- **Count enable:** `cnt_en = (state==RUNNING) && !stop && !reset`.
- **Prescaler:** counts 0..`TICKS_PER_SEC`-1 while `cnt_en` is high. `tick = cnt_en && (presc == TICKS_PER_SEC-1)`. On `tick`, the prescaler returns to 0.
  - It holds its value in PAUSED, so a partial second is preserved across a pause.
  - It is cleared on `reset`.
  - When `TICKS_PER_SEC`=1, the prescaler is zero-width and `tick = cnt_en`.
- **Seconds:** on `tick`, `seconds` increments, wrapping 59→0.
- **Minutes requests:**
  - `minutes_inc = tick && (seconds == 59)`, combinational and high for exactly one cycle per wrap.
  - `minutes_clr = reset`, a combinational pass-through.
  - The minutes counter handles its own 99→0 wrap; this block has no knowledge of the minutes value.
- **Simultaneous events:**
  - `stop` coinciding with a tick: the tick is dropped and `seconds` holds.
  - `reset` coinciding with a 59 wrap: `minutes_inc` is 0 and `minutes_clr` is 1.
- **Width rules:** `seconds` arithmetic is 6 bits. The prescaler is `$clog2(TICKS_PER_SEC)` bits.

## Timing
- **Reset values** while `rst_n`=0, applied immediately (asynchronous):
  - `state`=IDLE, `seconds`=0, prescaler=0, `running`=0.
  - `minutes_inc`=0 whenever `rst_n` is low.
  - `minutes_clr` follows `reset`.
- **Start latency:** with `start` sampled at edge E, `state`=RUNNING after E. The first `seconds` increment occurs at edge E+`TICKS_PER_SEC`.
- **Stop latency:** with `stop` sampled at edge E, there is no increment at E and PAUSED holds from E onward.
- **Registered outputs:** `seconds`, `state` and `running` change only on clock edges. `minutes_inc` and `minutes_clr` are valid within the same cycle, before the edge at which the minutes counter samples them.
- **Mid-second reset:** `rst_n` asserted mid-second discards the partial second. Deassertion must be synchronous to `clk`; this is the integrator's responsibility.

## Structure
- **Package `stopwatch_pkg`:**
  - state encodings `ST_IDLE`=2'b00, `ST_RUN`=2'b01, `ST_PAUSE`=2'b10
  - `SEC_MAX`=6'd59
  - `MIN_MAX`=8'd99 (shared with the minutes counter)
- **Sub-module `stopwatch_tick_gen`:** holds the parameterised prescaler.
  - Inputs: `clk`, `rst_n`, `en`, `clr`.
  - Output: `tick`.
  - This isolates the `TICKS_PER_SEC`=1 special case.
- **Top:** the FSM, the seconds register, and the combinational request logic.

## Test plan
1. **Full minute, `TICKS_PER_SEC`=1.** Release `rst_n`, then hold `start` for 1 cycle. `seconds` reaches 59 at start-edge+59. `minutes_inc`=1 only in the following cycle. At the next edge `seconds`=0, and the attached minutes counter reads 1.
2. **Pause and resume.** Assert `stop` when `seconds`=23: state is PAUSED and `seconds` stays 23 for 10 cycles. Assert `start`: the next increment gives 24.
3. **Priority.** `start`+`stop` in IDLE → stays IDLE. `start`+`stop` in RUNNING at `seconds`=5 → PAUSED with `seconds`=5. `reset`+`start` in PAUSED → IDLE with `seconds`=0.
4. **Clear at wrap.** `reset` at `seconds`=59 while RUNNING: `minutes_clr`=1 and `minutes_inc`=0 that cycle. Next state is IDLE, `seconds`=0, minutes=0.
5. **Prescaler hold, `TICKS_PER_SEC`=4.** `stop` after 2 running cycles into a second, wait 7 cycles, then `start`. The next `seconds` increment comes 2 running cycles later, not 4.
6. **Async reset mid-run.** Drop `rst_n` between edges at `seconds`=41. `seconds`=0, `state`=IDLE and `running`=0 before the next edge, with no further increments while `rst_n` stays low.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings and limits for the stopwatch run-control and minutes datapath.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } sw_state_t;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [7:0] MIN_MAX = 8'd99;

  // Next seconds value on a tick, wrapping 59 -> 0.
  function automatic logic [5:0] sec_wrap_inc(input logic [5:0] sec);
    return (sec == SEC_MAX) ? 6'd0 : sec + 6'd1;
  endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Prescaler dividing clk into one-second ticks; holds its count while en is low.
module stopwatch_tick_gen #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (TICKS_PER_SEC == 1) begin : g_direct
      // Every enabled cycle is a full second, so there is no state to keep.
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst_n, clr};
      assign tick = en;
    end else begin : g_presc
      localparam int W = $clog2(TICKS_PER_SEC);
      localparam logic [W-1:0] PRESC_MAX = W'(TICKS_PER_SEC - 1);

      logic [W-1:0] presc_reg;
      logic [W-1:0] presc_next;

      assign tick = en && (presc_reg == PRESC_MAX);

      always_comb begin
        presc_next = presc_reg;
        if (clr) begin
          presc_next = '0;
        end else if (en) begin
          presc_next = (presc_reg == PRESC_MAX) ? '0 : presc_reg + W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          presc_reg <= '0;
        end else begin
          presc_reg <= presc_next;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control: IDLE/RUNNING/PAUSED sequencer, seconds counter and
// same-cycle increment/clear requests for the external minutes counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       reset,
  output logic       minutes_inc,
  output logic       minutes_clr,
  output logic [5:0] seconds,
  output logic [1:0] state,
  output logic       running
);

  sw_state_t  state_reg;
  sw_state_t  state_next;
  logic [5:0] seconds_reg;
  logic [5:0] seconds_next;
  logic       cnt_en;
  logic       tick;

  // stop in the same cycle as a tick drops that tick rather than counting it.
  assign cnt_en = (state_reg == ST_RUN) && !stop && !reset;

  stopwatch_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cnt_en),
    .clr  (reset),
    .tick (tick)
  );

  always_comb begin
    state_next = state_reg;
    if (reset) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (start && !stop) state_next = ST_RUN;
        ST_RUN:   if (stop) state_next = ST_PAUSE;
        ST_PAUSE: if (start && !stop) state_next = ST_RUN;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    seconds_next = seconds_reg;
    if (reset) begin
      seconds_next = 6'd0;
    end else if (tick) begin
      seconds_next = sec_wrap_inc(seconds_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      seconds_reg <= 6'd0;
    end else begin
      state_reg   <= state_next;
      seconds_reg <= seconds_next;
    end
  end

  // tick already excludes reset, so a clear at the 59 wrap never also increments.
  assign minutes_inc = tick && (seconds_reg == SEC_MAX);
  assign minutes_clr = reset;

  assign seconds = seconds_reg;
  assign state   = state_reg;
  assign running = (state_reg == ST_RUN);

endmodule
